// File: rtl/operand_fetch_arbiter_if.sv
// Bus bundle between the operand-fetch requesters/SRAM environment (master)
// and operand_fetch_arbiter (slave).
interface operand_fetch_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic                      hold;
  logic [NUM_REQ-1:0]        gnt;
  logic                      mem_rd_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_rdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      fetch_stall;

  modport master (
    output req, req_addr, hold, mem_rdata,
    input  gnt, mem_rd_en, mem_addr, rsp_valid, rsp_data, fetch_stall
  );

  modport slave (
    input  req, req_addr, hold, mem_rdata,
    output gnt, mem_rd_en, mem_addr, rsp_valid, rsp_data, fetch_stall
  );
endinterface

// File: rtl/operand_fetch_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SRAM read port between NUM_REQ
// fetch requesters. Define OFA_STALL_CNT_EN to build the saturating stall counter.
module operand_fetch_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  operand_fetch_arbiter_if.slave bus,
  output logic [15:0]            stall_cycles
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] id;
  } tag_t;

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [NUM_REQ-1:0] rsp_vec;
  logic               grant_any;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   ptr_next;
  logic               stall;
  tag_t               pipe [RD_LAT];
  tag_t               tail;

  // Search downward from the farthest offset so the nearest eligible index
  // at or after ptr is the last one written and therefore wins.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    winner    = '0;
    eligible  = bus.req & ~busy & {NUM_REQ{~bus.hold}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[idx]) begin
        grant_any = 1'b1;
        winner    = PTR_W'(idx);
      end
    end
  end

  assign gnt_vec  = grant_any ? (NUM_REQ'(1) << winner) : '0;
  assign ptr_next = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign tail     = pipe[RD_LAT-1];
  assign rsp_vec  = tail.valid ? (NUM_REQ'(1) << tail.id) : '0;
  assign stall    = (|bus.req) & ~grant_any;

  assign bus.gnt         = gnt_vec;
  assign bus.mem_rd_en   = grant_any;
  assign bus.mem_addr    = grant_any ? bus.req_addr[winner*ADDR_W +: ADDR_W] : '0;
  assign bus.rsp_valid   = rsp_vec;
  assign bus.rsp_data    = tail.valid ? bus.mem_rdata : '0;
  assign bus.fetch_stall = stall;

  // NOTE: the tag pipeline is reset so reads in flight at reset never respond afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      busy <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      if (grant_any) ptr <= ptr_next;
      // A requester's own response clears busy; it cannot be granted in that cycle.
      busy    <= (busy & ~rsp_vec) | gnt_vec;
      pipe[0] <= '{valid: grant_any, id: winner};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

`ifdef OFA_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/operand_fetch_arbiter.md
Name: operand_fetch_arbiter

Overview:
- Shares the single read port of the operand SRAM between NUM_REQ fetch requesters (row fetch, column fetch, prefetch) of the matrix-multiplier datapath.
- Round-robin grant with fixed memory read latency; routes read data back to the owning requester with a per-requester valid.
- Enforces at most one outstanding read per requester.
- Exports a stall flag the sequencing control unit uses as its fetch-stall input.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 8, SRAM address width
- DATA_W, 32, SRAM data width
- RD_LAT, 2, cycles from mem_rd_en to valid mem_rdata (1..4)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  NUM_REQ  per-requester read request, level; held until granted
- req_addr  input  NUM_REQ*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W]; stable while req[i]=1
- hold  input  1  blocks all new grants when 1 (memory busy/refresh)
- gnt  output  NUM_REQ  one-hot grant pulse, at most one bit set
- mem_rd_en  output  1  SRAM read strobe
- mem_addr  output  ADDR_W  SRAM read address
- mem_rdata  input  DATA_W  SRAM read data, valid RD_LAT cycles after mem_rd_en
- rsp_valid  output  NUM_REQ  one-hot response-valid pulse
- rsp_data  output  DATA_W  response data
- fetch_stall  output  1  1 when any req is pending but no grant issues this cycle
- stall_cycles  output  16  saturating stall-cycle counter (optional feature)

Behaviour:
- Reset values: gnt=0, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, fetch_stall=0, stall_cycles=0; RR pointer=0; latency pipeline and busy[] cleared.
- Eligibility: eligible[i] = req[i] & ~busy[i] & ~hold.
- Grant is combinational, same cycle: winner = first eligible index searching from ptr upward, wrapping NUM_REQ-1 -> 0. gnt[winner]=1; mem_rd_en=|gnt; mem_addr=req_addr[winner], else 0.
- On a grant, at the clock edge: ptr <= winner+1 (wraps to 0 after NUM_REQ-1); busy[winner] <= 1; the tag {valid=1, id=winner} enters an RD_LAT-deep shift register. No grant: ptr holds; a valid=0 bubble enters.
- Response: when the pipeline tail is valid, rsp_valid[id]=1 and rsp_data=mem_rdata, combinational from the tail, exactly RD_LAT cycles after the gnt cycle. With tail invalid: rsp_valid=0 and rsp_data=0.
- busy[id] clears on the response cycle, so that requester is eligible again the next cycle, not the same one.
- Throughput: one grant per cycle across requesters. A single requester achieves one read per RD_LAT+1 cycles.
- Requester protocol: a requester deasserting req before its grant is legal; no grant results.
- fetch_stall = |req & ~mem_rd_en, combinational.
- Simultaneous events:
  - A response to i and req[i] in the same cycle: i not granted that cycle.
  - hold=1 while responses are in flight: responses still return; only grants are blocked.
- Reset mid-operation: in-flight tags are discarded; no rsp_valid issues for them after reset release.
- No state machine beyond ptr/busy/pipeline; the block is always in its arbitrating state.

Optional Feature:
- Macro: OFA_STALL_CNT_EN.
- Defined: stall_cycles increments by 1 each cycle fetch_stall=1, saturates at 16'hFFFF, resets to 0 only on rst_n.
- Undefined: stall_cycles is tied to 0 and no counter logic is generated; all other behaviour is identical.

Test Plan:
- req=2'b01, addr0=8'h10, RD_LAT=2 -> gnt=01 and mem_addr=8'h10 in cycle 0; rsp_valid=01 in cycle 2 with rsp_data = memory word at 8'h10.
- req=2'b11 held continuously from ptr=0 -> grants alternate 01,10,... in the first two cycles, then resume on each requester's busy clear; no requester is granted twice in a row while the other is eligible.
- req=2'b11 with hold=1 for 3 cycles -> no gnt, fetch_stall=1 for 3 cycles, stall_cycles=3 with OFA_STALL_CNT_EN (0 without); first grant after hold drops goes to ptr's requester.
- req[0] held constantly alone -> grants every RD_LAT+1=3 cycles; never a second grant while busy[0]=1.
- Two grants issued, then rst_n pulsed low for 1 cycle -> all outputs 0, no rsp_valid in the following 4 cycles.
- NUM_REQ=3, ptr=2, req=3'b101 -> gnt=100, then gnt=001 on the next cycle.
